// File: rtl/count_en_gen_pkg.sv
// Shared types and default widths for the enable-strobe generator.
package count_en_gen_pkg;

  localparam int DIV_WIDTH_DEF   = 8;
  localparam int BURST_WIDTH_DEF = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/count_en_prescaler.sv
// Loadable down-counter; tick is high while the count sits at zero.
// Load has priority over decrement; the count holds when neither is asserted.
module count_en_prescaler #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         tick
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec) begin
      cnt <= cnt - W'(1);
    end
  end

  assign tick = (cnt == '0);

endmodule

// File: rtl/count_en_gen.sv
// Divides clk by div+1 and emits registered one-cycle en strobes, continuous or as a burst.
// Define COUNT_EN_GEN_PAUSE_EN to add a pause input that freezes a running sequence.
module count_en_gen
  import count_en_gen_pkg::*;
#(
  parameter int DIV_WIDTH   = DIV_WIDTH_DEF,
  parameter int BURST_WIDTH = BURST_WIDTH_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   stop,
`ifdef COUNT_EN_GEN_PAUSE_EN
  input  logic                   pause,
`endif
  input  logic [DIV_WIDTH-1:0]   div,
  input  logic [BURST_WIDTH-1:0] burst_len,
  input  logic                   burst_mode,
  output logic                   en,
  output logic                   busy,
  output logic                   done
);

  state_t                 state, state_nxt;
  logic [DIV_WIDTH-1:0]   div_q;
  logic [BURST_WIDTH-1:0] len_q;
  logic                   mode_q;
  logic [BURST_WIDTH-1:0] pcnt;
  logic [BURST_WIDTH-1:0] last_idx;
  logic                   hold;
  logic                   accept, advance, tick, strobe, last;
  logic                   en_d, done_d, busy_d;

`ifdef COUNT_EN_GEN_PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif

  // burst_len of 0 wraps to all-ones here, giving a full 2^BURST_WIDTH burst
  assign last_idx = len_q - BURST_WIDTH'(1);
  assign accept   = (state == IDLE) && start && !stop;
  assign advance  = (state == RUN) && !stop && !hold;
  assign strobe   = advance && tick;
  assign last     = strobe && mode_q && (pcnt == last_idx);

  count_en_prescaler #(.W(DIV_WIDTH)) u_prescaler (
    .clk      (clk),
    .rst      (rst),
    .load     (accept || strobe),
    .dec      (advance && !tick),
    .load_val (accept ? div : div_q),
    .tick     (tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = RUN;
      RUN:     if (stop || last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    en_d   = strobe;
    done_d = last;
    busy_d = (state_nxt == RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en     <= 1'b0;
      done   <= 1'b0;
      busy   <= 1'b0;
      div_q  <= '0;
      len_q  <= '0;
      mode_q <= 1'b0;
      pcnt   <= '0;
    end else begin
      en   <= en_d;
      done <= done_d;
      busy <= busy_d;
      if (accept) begin
        div_q  <= div;
        len_q  <= burst_len;
        mode_q <= burst_mode;
        pcnt   <= '0;
      end else if (strobe) begin
        pcnt <= pcnt + BURST_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_count_en_gen.sv
// Bench for count_en_gen: expected strobe/done edge numbers are queued at launch and matched as they appear.
module tb_count_en_gen;

  localparam int DW = 8;
  localparam int BW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          stop = 1'b0;
  logic [DW-1:0] div = '0;
  logic [BW-1:0] burst_len = '0;
  logic          burst_mode = 1'b0;
  logic          en, busy, done;
`ifdef COUNT_EN_GEN_PAUSE_EN
  logic          pause = 1'b0;
`endif

  count_en_gen #(.DIV_WIDTH(DW), .BURST_WIDTH(BW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .stop       (stop),
`ifdef COUNT_EN_GEN_PAUSE_EN
    .pause      (pause),
`endif
    .div        (div),
    .burst_len  (burst_len),
    .burst_mode (burst_mode),
    .en         (en),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int edge_no = 0;
  always @(posedge clk) edge_no <= edge_no + 1;

  int checks = 0;
  int errors = 0;
  int exp_en_q[$];
  int exp_done_q[$];

  // Downstream 4-bit counter driven by en
  logic [BW-1:0] dcnt;
  logic          dcnt_clr = 1'b0;
  logic          saw_wrap;
  always @(posedge clk) begin
    if (rst || dcnt_clr) begin
      dcnt     <= '0;
      saw_wrap <= 1'b0;
    end else if (en) begin
      dcnt <= dcnt + 1'b1;
      if (dcnt == 4'hF) saw_wrap <= 1'b1;
    end
  end

  // Scoreboard: every observed strobe/done is popped against its queued edge number
  always @(negedge clk) begin
    int e;
    if (en === 1'b1) begin
      checks++;
      if (exp_en_q.size() == 0) begin
        errors++;
        $display("FAIL en_unexpected: strobe seen after edge %0d, required none", edge_no);
      end else begin
        e = exp_en_q.pop_front();
        if (edge_no !== e) begin
          errors++;
          $display("FAIL en_timing: strobe after edge %0d, required after edge %0d", edge_no, e);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (exp_done_q.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: done seen after edge %0d, required none", edge_no);
      end else begin
        e = exp_done_q.pop_front();
        if (edge_no !== e || en !== 1'b1 || busy !== 1'b0) begin
          errors++;
          $display("FAIL done_cycle: done after edge %0d en=%b busy=%b, required edge %0d en=1 busy=0",
                   edge_no, en, busy, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic launch(input int d, input int bl, input bit bm, output int t);
    div        = DW'(d);
    burst_len  = BW'(bl);
    burst_mode = bm;
    start      = 1'b1;
    t          = edge_no + 1;
    @(negedge clk);
    start      = 1'b0;
    div        = DW'($urandom);
    burst_len  = BW'($urandom);
    burst_mode = 1'($urandom);
  endtask

  task automatic push_burst(input int t, input int d, input int n, input bit with_done);
    for (int j = 1; j <= n; j++) exp_en_q.push_back(t + j * (d + 1));
    if (with_done) exp_done_q.push_back(t + n * (d + 1));
  endtask

  task automatic wait_edge(input int x);
    while (edge_no < x) @(negedge clk);
  endtask

  task automatic clear_dcnt();
    dcnt_clr = 1'b1;
    @(negedge clk);
    dcnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (en !== 1'b0) begin errors++; $display("FAIL reset_en: en=%b, required 0", en); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: busy=%b, required 0", busy); end
    checks++;
    if (done !== 1'b0) begin errors++; $display("FAIL reset_done: done=%b, required 0", done); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_burst_basic();
    int t;
    clear_dcnt();
    launch(2, 4, 1'b1, t);
    push_burst(t, 2, 4, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy: busy=%b, required 1", busy); end
    wait_edge(t + 13);
    checks++;
    if (busy !== 1'b0 || dcnt !== 4'd4) begin
      errors++;
      $display("FAIL basic_end: busy=%b counter=%0d, required busy=0 counter=4", busy, dcnt);
    end
    checks++;
    if (exp_en_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL basic_pending: %0d en / %0d done outstanding, required 0/0", exp_en_q.size(), exp_done_q.size());
    end
    exp_en_q.delete(); exp_done_q.delete();
  endtask

  task automatic test_burst_full();
    int t;
    clear_dcnt();
    launch(0, 0, 1'b1, t);
    push_burst(t, 0, 16, 1'b1);
    wait_edge(t + 17);
    checks++;
    if (dcnt !== 4'd0 || saw_wrap !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_end: counter=%0d wrapped=%b busy=%b, required counter=0 wrapped=1 busy=0", dcnt, saw_wrap, busy);
    end
    checks++;
    if (exp_en_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL full_pending: %0d en / %0d done outstanding, required 0/0", exp_en_q.size(), exp_done_q.size());
    end
    exp_en_q.delete(); exp_done_q.delete();
  endtask

  task automatic test_back_to_back();
    int t, t2;
    launch(0, 1, 1'b1, t);
    push_burst(t, 0, 1, 1'b1);
    wait_edge(t + 1);
    launch(0, 2, 1'b1, t2);
    push_burst(t2, 0, 2, 1'b1);
    checks++;
    if (busy !== 1'b1) begin errors++; $display("FAIL relaunch_busy: busy=%b, required 1", busy); end
    wait_edge(t2 + 3);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL relaunch_end: busy=%b, required 0", busy); end
    checks++;
    if (exp_en_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL relaunch_pending: %0d en / %0d done outstanding, required 0/0", exp_en_q.size(), exp_done_q.size());
    end
    exp_en_q.delete(); exp_done_q.delete();
  endtask

  task automatic test_stop_due();
    int t;
    launch(1, 0, 1'b0, t);
    exp_en_q.push_back(t + 2);
    exp_en_q.push_back(t + 4);
    wait_edge(t + 5);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || en !== 1'b0) begin
      errors++;
      $display("FAIL stop_due: busy=%b en=%b, required busy=0 en=0", busy, en);
    end
    wait_edge(t + 10);
    checks++;
    if (busy !== 1'b0 || exp_en_q.size() != 0) begin
      errors++;
      $display("FAIL stop_after: busy=%b outstanding=%0d, required busy=0 outstanding=0", busy, exp_en_q.size());
    end
    exp_en_q.delete(); exp_done_q.delete();
  endtask

  task automatic test_start_stop_idle();
    int t;
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    stop  = 1'b0;
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_busy: busy=%b, required 0", busy); end
    repeat (4) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL start_stop_later: busy=%b, required 0", busy); end
    clear_dcnt();
    launch(1, 3, 1'b1, t);
    push_burst(t, 1, 3, 1'b1);
    wait_edge(t + 2);
    div        = '0;
    burst_len  = 4'd7;
    burst_mode = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    wait_edge(t + 7);
    checks++;
    if (dcnt !== 4'd3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_run: counter=%0d busy=%b, required counter=3 busy=0", dcnt, busy);
    end
    checks++;
    if (exp_en_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL start_in_run_pending: %0d en / %0d done outstanding, required 0/0", exp_en_q.size(), exp_done_q.size());
    end
    exp_en_q.delete(); exp_done_q.delete();
  endtask

  task automatic test_rst_mid();
    int t;
    clear_dcnt();
    launch(1, 5, 1'b1, t);
    exp_en_q.push_back(t + 2);
    exp_en_q.push_back(t + 4);
    wait_edge(t + 4);
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid: en=%b busy=%b done=%b, required 0/0/0", en, busy, done);
    end
    rst = 1'b0;
    checks++;
    if (exp_en_q.size() != 0) begin
      errors++;
      $display("FAIL rst_mid_strobes: %0d strobes missing before reset, required 0", exp_en_q.size());
    end
    exp_en_q.delete(); exp_done_q.delete();
    @(negedge clk);
    launch(1, 5, 1'b1, t);
    push_burst(t, 1, 5, 1'b1);
    wait_edge(t + 11);
    checks++;
    if (dcnt !== 4'd5 || exp_en_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL rst_relaunch: counter=%0d outstanding=%0d/%0d, required counter=5 outstanding=0/0",
               dcnt, exp_en_q.size(), exp_done_q.size());
    end
    exp_en_q.delete(); exp_done_q.delete();
  endtask

`ifdef COUNT_EN_GEN_PAUSE_EN
  task automatic test_pause();
    int t;
    clear_dcnt();
    launch(2, 3, 1'b1, t);
    exp_en_q.push_back(t + 3);
    exp_en_q.push_back(t + 9);
    exp_en_q.push_back(t + 12);
    exp_done_q.push_back(t + 12);
    wait_edge(t + 3);
    pause = 1'b1;
    wait_edge(t + 6);
    checks++;
    if (busy !== 1'b1 || en !== 1'b0) begin
      errors++;
      $display("FAIL pause_hold: busy=%b en=%b, required busy=1 en=0", busy, en);
    end
    pause = 1'b0;
    wait_edge(t + 13);
    checks++;
    if (dcnt !== 4'd3 || exp_en_q.size() != 0 || exp_done_q.size() != 0) begin
      errors++;
      $display("FAIL pause_end: counter=%0d outstanding=%0d/%0d, required counter=3 outstanding=0/0",
               dcnt, exp_en_q.size(), exp_done_q.size());
    end
    exp_en_q.delete(); exp_done_q.delete();
  endtask
`endif

  initial begin
    test_reset();
    test_burst_basic();
    test_burst_full();
    test_back_to_back();
    test_stop_due();
    test_start_stop_idle();
    test_rst_mid();
`ifdef COUNT_EN_GEN_PAUSE_EN
    test_pause();
`endif
    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/count_en_gen.md
# count_en_gen

Programmable enable-strobe generator that sits directly upstream of the free-running counter and drives its `en` input. It divides `clk` by a software-set ratio and emits single-cycle enable strobes, either continuously or as a fixed-length burst, with start/stop control and busy/done status. Downstream, a burst of N strobes advances the counter by exactly N.

## Interface
- `DIV_WIDTH`, 8: width of the prescaler reload value.
- `BURST_WIDTH`, 4: width of the burst length; matches the counter `WIDTH` so one full burst wraps it once.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle launch request.
- `stop`  in  1  single-cycle abort request.
- `div`  in  DIV_WIDTH  strobe period minus one; sampled only on an accepted `start`.
- `burst_len`  in  BURST_WIDTH  number of strobes in burst mode; sampled only on an accepted `start`.
- `burst_mode`  in  1  1 = burst, 0 = continuous; sampled only on an accepted `start`.
- `en`  out  1  registered single-cycle strobe to the counter.
- `busy`  out  1  high while in RUN.
- `done`  out  1  registered single-cycle pulse on burst completion.

## Operation
- States: IDLE, RUN.
- Reset: state = IDLE. `en`, `busy`, `done`, prescaler, pulse counter and all latched config registers are cleared to 0.
- IDLE, `start`=1 and `stop`=0:
  - latch `div`, `burst_len` and `burst_mode`;
  - load the prescaler with `div` and clear the pulse counter;
  - go to RUN.
- IDLE with `start`=1 and `stop`=1: `stop` wins; stay in IDLE.
- RUN, on every edge with `stop`=0:
  - prescaler == 0: `en`<=1, reload the prescaler from the latched `div`, pulse counter +1;
  - otherwise: `en`<=0, prescaler −1.
- Burst completion, RUN with burst mode:
  - The issued strobe is the last one when the pulse counter before the increment equals latched `burst_len`−1, modulo 2^BURST_WIDTH.
  - On that edge: `en`<=1, `done`<=1, state <= IDLE.
  - `burst_len`=0 means 2^BURST_WIDTH strobes (16 at the defaults).
- Continuous mode: the pulse counter wraps silently and `done` never asserts.
- RUN with `stop`=1: state <= IDLE and `en`<=0 on that edge. `stop` has priority over a due strobe. `done` is not asserted.
- `start` while in RUN is ignored. Inputs `div`, `burst_len` and `burst_mode` changing mid-run have no effect.
- `stop` while in IDLE is ignored.
- `busy` = (state == RUN), registered.
- `done` and `en` are each high for exactly one cycle per event.

## Timing
- `start` sampled at edge T:
  - `busy`=1 from T;
  - first `en` high in the cycle following edge T+div+1;
  - strobe period thereafter is div+1 cycles.
- `div`=0: `en` stays high continuously from edge T+1 until the burst ends or `stop` is taken.
- Last strobe of a burst: `en`=1 and `done`=1 in the same cycle, with `busy`=0 in that same cycle.
- Earliest relaunch: a `start` sampled on the edge after `done` is accepted.
- `rst` mid-run: outputs are 0 at the next edge. No `done` is issued and no partial strobe is stretched.

## Configuration
- `COUNT_EN_GEN_PAUSE_EN` defined:
  - adds input `pause` (1 bit);
  - while `pause`=1 in RUN, the prescaler and pulse counter hold, `en`=0, and `busy` stays 1;
  - `stop` overrides `pause`.
- `COUNT_EN_GEN_PAUSE_EN` undefined: the `pause` port does not exist and behaviour is as above.

## Structure
- Package `count_en_gen_pkg` holds:
  - the state enum (IDLE, RUN);
  - default width constants `DIV_WIDTH_DEF`=8 and `BURST_WIDTH_DEF`=4.
- Sub-module `count_en_prescaler` is a loadable down-counter with a zero-detect tick output. The top level owns the FSM, pulse counter and outputs.

## Test plan
- Reset, then `start` with div=2, burst_mode=1, burst_len=4 -> `en` high at cycles T+3, T+6, T+9 and T+12; `done`=1 together with the 4th strobe; a downstream 4-bit counter reads 4.
- div=0, burst_len=0, burst mode -> 16 back-to-back strobes, one `done`; the downstream counter wraps 15->0.
- Continuous mode with div=1 and `stop` raised on the cycle a strobe is due -> no strobe issued, `busy`=0 next cycle, `done` stays 0.
- `start` and `stop` in the same cycle in IDLE -> `busy` stays 0 and `en` never pulses. A second `start` during RUN is ignored and the strobe count is unchanged.
- `rst` asserted mid-burst (after 2 of 5 strobes) -> all outputs 0 next edge; a fresh `start` produces a full 5-strobe burst.
- With `COUNT_EN_GEN_PAUSE_EN`: `pause` held for 3 cycles mid-burst -> strobe spacing extends by 3 cycles and the total strobe count is unchanged.
